// File: rtl/samp_packer_pkg.sv
// rtl/samp_packer_pkg.sv - shared definitions for the sample packetizer
// Contents: FSM state encoding (declared in packet field order), default
// start marker, word geometry and the checksum step helper.
package samp_packer_pkg;

  // Default packet start marker.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h7E;

  // Bytes per sample word on the wire (least significant byte first).
  localparam int WORD_BYTES = 4;

  // The declaration order follows the packet layout:
  // SYNC, SEQ, N, then N words of data (each preceded by a LOAD), then CHK.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_SEQ  = 3'd2,
    ST_CNT  = 3'd3,
    ST_LOAD = 3'd4,
    ST_DATA = 3'd5,
    ST_SUM  = 3'd6
  } state_t;

  // Running checksum update; SYNC is never folded in.
  function automatic logic [7:0] chk_step(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

endpackage

// File: rtl/samp_packer_if.sv
// rtl/samp_packer_if.sv - sample-in / byte-out stream bundle for samp_packer
// Ports (signals):
//   samp_stream_data[31:0]  sample word, valid while samp_stream_avail
//   samp_stream_count[7:0]  words currently streamable
//   samp_stream_avail       upstream word present
//   samp_stream_pull        consume current word this cycle
//   tx_data[7:0]            outgoing packet byte
//   tx_avail                tx_data valid
//   tx_pull                 downstream accepts byte with tx_avail
// Modports: master = packer side, slave = upstream/downstream side.
interface samp_packer_if;
  logic [31:0] samp_stream_data;
  logic [7:0]  samp_stream_count;
  logic        samp_stream_avail;
  logic        samp_stream_pull;
  logic [7:0]  tx_data;
  logic        tx_avail;
  logic        tx_pull;

  modport master (
    input  samp_stream_data, samp_stream_count, samp_stream_avail, tx_pull,
    output samp_stream_pull, tx_data, tx_avail
  );

  modport slave (
    output samp_stream_data, samp_stream_count, samp_stream_avail, tx_pull,
    input  samp_stream_pull, tx_data, tx_avail
  );
endinterface

// File: rtl/samp_packer.sv
// rtl/samp_packer.sv - packs 32-bit samples into SYNC/SEQ/N/data/CHK byte packets
// Ports:
//   clk     sole clock, rising edge
//   rst     asynchronous active-high reset
//   enable  permits starting new packets
//   busy    high in every state except IDLE
//   bus     samp_packer_if.master (sample input stream, byte output stream)
module samp_packer
  import samp_packer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         SEQ_W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          busy,
  samp_packer_if.master bus
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  state_t           state, state_nxt;
  logic [SEQ_W-1:0] seq;
  logic [7:0]       n;
  logic [7:0]       word_cnt;
  logic [1:0]       byte_idx;
  logic [31:0]      shreg;
  logic [7:0]       chk;

  logic start;
  logic accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Outputs are decoded from state alone (plus avail in LOAD), so tx_data
  // holds steady while the downstream withholds tx_pull.
  always_comb begin
    state_nxt            = state;
    bus.tx_avail         = 1'b0;
    bus.tx_data          = 8'h00;
    bus.samp_stream_pull = 1'b0;
    start                = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && bus.samp_stream_avail && (bus.samp_stream_count != 8'd0)) begin
          start     = 1'b1;
          state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        bus.tx_avail = 1'b1;
        bus.tx_data  = SYNC_BYTE;
        if (bus.tx_pull) state_nxt = ST_SEQ;
      end
      ST_SEQ: begin
        bus.tx_avail = 1'b1;
        bus.tx_data  = seq;
        if (bus.tx_pull) state_nxt = ST_CNT;
      end
      ST_CNT: begin
        bus.tx_avail = 1'b1;
        bus.tx_data  = n;
        if (bus.tx_pull) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        // Waits here with no timeout until upstream has a word.
        bus.samp_stream_pull = bus.samp_stream_avail;
        if (bus.samp_stream_avail) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        bus.tx_avail = 1'b1;
        bus.tx_data  = shreg[7:0];
        if (bus.tx_pull && (byte_idx == LAST_BYTE))
          state_nxt = (word_cnt == n) ? ST_SUM : ST_LOAD;
      end
      ST_SUM: begin
        bus.tx_avail = 1'b1;
        bus.tx_data  = chk;
        if (bus.tx_pull) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = bus.tx_avail && bus.tx_pull;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq      <= '0;
      n        <= 8'd0;
      word_cnt <= 8'd0;
      byte_idx <= 2'd0;
      shreg    <= 32'd0;
      chk      <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          // N is frozen here; later count changes do not affect this packet.
          if (start) begin
            n        <= bus.samp_stream_count;
            chk      <= 8'd0;
            word_cnt <= 8'd0;
          end
        end
        ST_SEQ:  if (accept) chk <= chk_step(chk, seq);
        ST_CNT:  if (accept) chk <= chk_step(chk, n);
        ST_LOAD: begin
          if (bus.samp_stream_avail) begin
            shreg    <= bus.samp_stream_data;
            word_cnt <= word_cnt + 8'd1;
            byte_idx <= 2'd0;
          end
        end
        ST_DATA: begin
          if (accept) begin
            chk      <= chk_step(chk, shreg[7:0]);
            shreg    <= {8'h00, shreg[31:8]};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        ST_SUM:  if (accept) seq <= seq + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/samp_packer.md
SAMP_PACKER -- requirements
Module: samp_packer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h7E, is the packet start marker.
REQ-002 Parameter SEQ_W, default 8, is the sequence counter width; only 8 is supported.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 enable  input  1  permits starting new packets.
REQ-007 samp_stream_data  input  32  sample word; valid while samp_stream_avail.
REQ-008 samp_stream_count  input  8  words currently streamable (upstream-registered).
REQ-009 samp_stream_avail  input  1  upstream word present.
REQ-010 samp_stream_pull  output  1  consumes the current word in the same cycle.
REQ-011 tx_data  output  8  outgoing packet byte.
REQ-012 tx_avail  output  1  tx_data valid.
REQ-013 tx_pull  input  1  downstream accepts the byte when high with tx_avail.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Packet format: SYNC_BYTE, SEQ, N, then N words as 4 bytes each, least significant byte first, then CHK.
REQ-016 CHK is the XOR of SEQ, N and all data bytes; SYNC_BYTE is excluded.
REQ-017 States: IDLE, SYNC, SEQ, CNT, LOAD, DATA, SUM.
REQ-018 IDLE to SYNC occurs when enable && samp_stream_avail && samp_stream_count!=0; N latches samp_stream_count on that edge.
REQ-019 tx_avail rises on the cycle after the IDLE exit (1-cycle latency), with tx_data=SYNC_BYTE.
REQ-020 A byte advances only on tx_avail && tx_pull; tx_data is stable while tx_avail && !tx_pull.
REQ-021 Transitions on byte accept: SYNC->SEQ, SEQ->CNT, CNT->LOAD, fourth DATA byte->LOAD (words remain) or ->SUM (N words sent), SUM->IDLE.
REQ-022 In LOAD, tx_avail=0 and samp_stream_pull = samp_stream_avail (combinational).
REQ-023 In LOAD, samp_stream_data latches into a 32-bit shift register on the pull cycle; the state then goes to DATA.
REQ-024 In LOAD, if samp_stream_avail is low the block stalls indefinitely, with no timeout and no pull.
REQ-025 samp_stream_pull is never high outside LOAD; pulls are therefore spaced at least 5 cycles apart, which tolerates upstream avail/count lag.
REQ-026 Exactly N pulls occur per packet.
REQ-027 The word counter is 8-bit, counts 1..N, and never wraps.
REQ-028 SEQ increments modulo 256 on SUM accept (255->0).
REQ-029 enable deasserting mid-packet has no effect; the packet completes and no new packet starts.
REQ-030 A samp_stream_count change after the IDLE exit is ignored for the current packet.
REQ-031 The running checksum clears on the IDLE exit and updates on each accepted SEQ, CNT and DATA byte.

Reset
REQ-032 rst forces IDLE, SEQ=0, N=0, checksum=0, shift register=0, tx_avail=0, tx_data=0, busy=0, samp_stream_pull=0, regardless of state.
REQ-033 Reset mid-packet discards the packet; no partial-packet recovery.
REQ-034 The first packet after reset carries SEQ=0.

Structure
REQ-035 State encoding, the SYNC_BYTE default and the packet field order belong in the shared sampleq package.
REQ-036 The block is flat, with a single FSM and datapath; no sub-module.

Verification
REQ-037 N=1, word 32'h11223344, tx_pull=1 continuously -> bytes 7E 00 01 44 33 22 11 45, with exactly one pull.
REQ-038 tx_pull held low 3 cycles on the SEQ byte -> tx_data stays 00, tx_avail stays high, and no state advance.
REQ-039 N=3 with samp_stream_avail dropped for 10 cycles before word 2 -> the block stalls in LOAD with tx_avail=0, then resumes; 3 pulls, 16 bytes total.
REQ-040 257 back-to-back N=1 packets -> SEQ runs 00..FF then 00.
REQ-041 rst asserted during DATA byte 2 -> tx_avail and pull go low immediately; the next packet starts with SYNC, SEQ=00.
REQ-042 enable dropped during CNT of an N=2 packet -> the packet completes (12 bytes), then the block stays IDLE despite samp_stream_avail=1.
